// File: rtl/fft_butterfly_pkg.sv
// Shared FFT constants and complex {re,im} container types used by the
// butterfly, the address generator and the twiddle ROM.
package fft_pkg;
   localparam int N      = 32;
   localparam int LOG2N  = 5;
   localparam int DW_DEF = 16;
   localparam int TW_DEF = 16;
   localparam int AW     = LOG2N;
   localparam int TWAW   = LOG2N - 1;

   typedef struct packed {
      logic signed [DW_DEF-1:0] re;
      logic signed [DW_DEF-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW_DEF-1:0] re;
      logic signed [TW_DEF-1:0] im;
   } twid_t;

   function automatic cplx_t cplx_pack(input logic signed [DW_DEF-1:0] re,
                                       input logic signed [DW_DEF-1:0] im);
      cplx_t c;
      c.re = re;
      c.im = im;
      return c;
   endfunction

   function automatic logic signed [DW_DEF-1:0] cplx_re(input cplx_t c);
      return c.re;
   endfunction

   function automatic logic signed [DW_DEF-1:0] cplx_im(input cplx_t c);
      return c.im;
   endfunction
endpackage

// File: rtl/fft_butterfly_cmul.sv
// Two-cycle complex multiplier W*B: partial products, then sum, round
// (add 2^(TW-2), arithmetic shift by TW-1) and saturate to DW bits.
module fft_cmul
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [2*DW-1:0] b,
   input  logic [2*TW-1:0] w,
   output logic            out_valid,
   output logic            busy,
   output logic [2*DW-1:0] wb
);
   localparam int PW = DW + TW;
   localparam logic signed [PW:0] RND = (PW+1)'(2**(TW-2));

   logic signed [DW-1:0] b_re, b_im;
   logic signed [TW-1:0] w_re, w_im;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [PW:0]   re_full, im_full, re_shift, im_shift;
   logic                 v2, v3;

   assign b_re = b[2*DW-1:DW];
   assign b_im = b[DW-1:0];
   assign w_re = w[2*TW-1:TW];
   assign w_im = w[TW-1:0];

   function automatic logic [DW-1:0] sat(input logic signed [PW:0] x);
      if (x[PW:DW-1] == {(PW-DW+2){x[PW]}})
         return x[DW-1:0];
      else
         return x[PW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v2 <= in_valid;
         v3 <= v2;
      end
   end

   always_ff @(posedge clk) begin
      p_rr <= PW'(b_re) * PW'(w_re);
      p_ii <= PW'(b_im) * PW'(w_im);
      p_ri <= PW'(b_re) * PW'(w_im);
      p_ir <= PW'(b_im) * PW'(w_re);
   end

   always_comb begin
      re_full  = (PW+1)'(p_rr) - (PW+1)'(p_ii) + RND;
      im_full  = (PW+1)'(p_ri) + (PW+1)'(p_ir) + RND;
      re_shift = re_full >>> (TW-1);
      im_shift = im_full >>> (TW-1);
   end

   always_ff @(posedge clk) begin
      wb <= {sat(re_shift), sat(im_shift)};
   end

   assign out_valid = v3;
   assign busy      = v2 | v3;
endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly X=A+W*B, Y=A-W*B, fixed 4-cycle issue-to-write latency.
// Define FFT_BFLY_SCALE_EN for a rounded 1/2 scaling of each output instead of saturation.
module fft_butterfly
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [AW-1:0]   address_a,
   input  logic [AW-1:0]   address_b,
   input  logic [TWAW-1:0] twiddle_address,
   output logic [AW-1:0]   rd_addr_a,
   output logic [AW-1:0]   rd_addr_b,
   output logic [TWAW-1:0] tw_addr,
   input  logic [2*DW-1:0] rd_data_a,
   input  logic [2*DW-1:0] rd_data_b,
   input  logic [2*TW-1:0] tw_data,
   output logic            wr_en,
   output logic [AW-1:0]   wr_addr_a,
   output logic [AW-1:0]   wr_addr_b,
   output logic [2*DW-1:0] wr_data_a,
   output logic [2*DW-1:0] wr_data_b,
   output logic            busy
);
   logic            v0, v1, v3, cmul_busy;
   logic [AW-1:0]   a0_addr, b0_addr, a1_addr, b1_addr;
   logic [AW-1:0]   a2_addr, b2_addr, a3_addr, b3_addr;
   logic [2*DW-1:0] a1, b1, a2, a3, wb;
   logic [2*TW-1:0] w1;
   logic [DW:0]     x_re, x_im, y_re, y_im;

   assign rd_addr_a = address_a;
   assign rd_addr_b = address_b;
   assign tw_addr   = twiddle_address;

   function automatic logic [DW-1:0] fin(input logic [DW:0] s);
`ifdef FFT_BFLY_SCALE_EN
      return DW'((s + (DW+1)'(1)) >> 1);
`else
      if (s[DW] == s[DW-1])
         return s[DW-1:0];
      else
         return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else begin
         v0 <= in_valid;
         v1 <= v0;
      end
   end

   // Data and address pipeline runs freely; only the valid bits qualify it.
   always_ff @(posedge clk) begin
      a0_addr <= address_a;
      b0_addr <= address_b;
      a1_addr <= a0_addr;
      b1_addr <= b0_addr;
      a2_addr <= a1_addr;
      b2_addr <= b1_addr;
      a3_addr <= a2_addr;
      b3_addr <= b2_addr;
      a1      <= rd_data_a;
      b1      <= rd_data_b;
      w1      <= tw_data;
      a2      <= a1;
      a3      <= a2;
   end

   fft_cmul #(.DW(DW), .TW(TW)) u_cmul (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v1),
      .b         (b1),
      .w         (w1),
      .out_valid (v3),
      .busy      (cmul_busy),
      .wb        (wb)
   );

   always_comb begin
      x_re = {a3[2*DW-1], a3[2*DW-1:DW]} + {wb[2*DW-1], wb[2*DW-1:DW]};
      x_im = {a3[DW-1], a3[DW-1:0]} + {wb[DW-1], wb[DW-1:0]};
      y_re = {a3[2*DW-1], a3[2*DW-1:DW]} - {wb[2*DW-1], wb[2*DW-1:DW]};
      y_im = {a3[DW-1], a3[DW-1:0]} - {wb[DW-1], wb[DW-1:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en     <= 1'b0;
         wr_addr_a <= '0;
         wr_addr_b <= '0;
         wr_data_a <= '0;
         wr_data_b <= '0;
      end else begin
         wr_en     <= v3;
         wr_addr_a <= a3_addr;
         wr_addr_b <= b3_addr;
         wr_data_a <= {fin(x_re), fin(x_im)};
         wr_data_b <= {fin(y_re), fin(y_im)};
      end
   end

   assign busy = v0 | v1 | cmul_busy | wr_en;
endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly: directed corner cases, reset mid-stream,
// back-to-back issue and randomized traffic against an arithmetic reference model.
module tb_fft_butterfly;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [4:0]  address_a, address_b;
   logic [3:0]  twiddle_address;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [3:0]  tw_addr;
   logic [31:0] rd_data_a, rd_data_b, tw_data;
   logic        wr_en;
   logic [4:0]  wr_addr_a, wr_addr_b;
   logic [31:0] wr_data_a, wr_data_b;
   logic        busy;

   typedef struct {
      logic [4:0]  aa;
      logic [4:0]  bb;
      logic [31:0] x;
      logic [31:0] y;
      int          issue;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mem[32];
   logic [31:0] twRom[16];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          wrCount = 0;

   fft_butterfly dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .address_a       (address_a),
      .address_b       (address_b),
      .twiddle_address (twiddle_address),
      .rd_addr_a       (rd_addr_a),
      .rd_addr_b       (rd_addr_b),
      .tw_addr         (tw_addr),
      .rd_data_a       (rd_data_a),
      .rd_data_b       (rd_data_b),
      .tw_data         (tw_data),
      .wr_en           (wr_en),
      .wr_addr_a       (wr_addr_a),
      .wr_addr_b       (wr_addr_b),
      .wr_data_a       (wr_data_a),
      .wr_data_b       (wr_data_b),
      .busy            (busy)
   );

   // Free-running clock and edge counter used to measure latency.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read data memory and twiddle ROM with one cycle of latency.
   always @(posedge clk) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      tw_data   <= twRom[tw_addr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] finish16(input longint v);
`ifdef FFT_BFLY_SCALE_EN
      return 16'((v + 1) >>> 1);
`else
      return 16'(clamp16(v));
`endif
   endfunction

   // Reference butterfly straight from the arithmetic definition.
   task automatic bflyModel(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                            output logic [31:0] x, output logic [31:0] y);
      longint ar, ai, br, bi, wr, wi, tr, ti;
      ar = longint'($signed(a[31:16]));
      ai = longint'($signed(a[15:0]));
      br = longint'($signed(b[31:16]));
      bi = longint'($signed(b[15:0]));
      wr = longint'($signed(w[31:16]));
      wi = longint'($signed(w[15:0]));
      tr = clamp16((br * wr - bi * wi + 16384) >>> 15);
      ti = clamp16((br * wi + bi * wr + 16384) >>> 15);
      x = {finish16(ar + tr), finish16(ai + ti)};
      y = {finish16(ar - tr), finish16(ai - ti)};
   endtask

   // Issue one butterfly at the next rising edge; call just after a falling edge.
   task automatic applyStimulus(input logic [4:0] aa, input logic [4:0] bb, input logic [3:0] ta);
      exp_t e;
      in_valid        = 1'b1;
      address_a       = aa;
      address_b       = bb;
      twiddle_address = ta;
      e.aa    = aa;
      e.bb    = bb;
      e.issue = cyc + 1;
      bflyModel(mem[aa], mem[bb], twRom[ta], e.x, e.y);
      expQ.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Scoreboard: every write must match the oldest outstanding butterfly.
   always @(negedge clk) begin
      if (!reset && wr_en) begin
         wrCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_wr", 64'(wr_en), 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_addr_a", 64'(wr_addr_a), 64'(e.aa));
            checkOutput("sb_addr_b", 64'(wr_addr_b), 64'(e.bb));
            checkOutput("sb_data_x", 64'(wr_data_a), 64'(e.x));
            checkOutput("sb_data_y", 64'(wr_data_b), 64'(e.y));
            checkOutput("sb_latency", 64'(cyc - e.issue), 64'd4);
         end
      end
   end

   task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] w, input logic [31:0] expX, input logic [31:0] expY);
      int issued;
      bit seen;
      mem[3]   = a;
      mem[7]   = b;
      twRom[5] = w;
      issued   = cyc + 1;
      applyStimulus(5'd3, 5'd7, 4'd5);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (wr_en) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput({tag, "_wr_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         checkOutput({tag, "_latency"}, 64'(cyc - issued), 64'd4);
         checkOutput({tag, "_addr"}, 64'({wr_addr_a, wr_addr_b}), 64'({5'd3, 5'd7}));
         checkOutput({tag, "_x"}, 64'(wr_data_a), 64'(expX));
         checkOutput({tag, "_y"}, 64'(wr_data_b), 64'(expY));
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lastWr;
      reset           = 1'b1;
      in_valid        = 1'b0;
      address_a       = '0;
      address_b       = '0;
      twiddle_address = '0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      for (int i = 0; i < 16; i++) twRom[i] = $urandom;

      repeat (3) @(negedge clk);
      checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_wr_addr", 64'({wr_addr_a, wr_addr_b}), 64'd0);
      checkOutput("reset_wr_data", {wr_data_a, wr_data_b}, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Unity, -j and saturation corner cases.
`ifdef FFT_BFLY_SCALE_EN
      runDirected("unity", {16'd100, 16'd50}, {16'd20, 16'hFFF6}, 32'h7FFF_0000,
                  32'h003C_0014, 32'h0028_001E);
      runDirected("minus_j", 32'h0, {16'd1000, 16'd0}, 32'h0000_8000,
                  32'h0000_FE0C, 32'h0000_01F4);
`else
      runDirected("unity", {16'd100, 16'd50}, {16'd20, 16'hFFF6}, 32'h7FFF_0000,
                  32'h0078_0028, 32'h0050_003C);
      runDirected("minus_j", 32'h0, {16'd1000, 16'd0}, 32'h0000_8000,
                  32'h0000_FC18, 32'h0000_03E8);
`endif
      runDirected("saturate", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                  32'h7FFF_0000, 32'h0001_0000);

      // Reset with three butterflies in flight.
      for (int i = 0; i < 3; i++)
         applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      #2 reset = 1'b1;
      expQ.delete();
      #1;
      checkOutput("midreset_wr_en", 64'(wr_en), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_wr_data", {wr_data_a, wr_data_b}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("post_reset_quiet", 64'({wr_en, busy}), 64'd0);
      end

      // Sixteen consecutive issues.
      lastWr = wrCount;
      for (int i = 0; i < 16; i++)
         applyStimulus(5'(i), 5'(31 - i), 4'(i));
      repeat (4) @(negedge clk);
      checkOutput("b2b_last_wr_en", 64'(wr_en), 64'd1);
      checkOutput("b2b_busy_held", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("b2b_busy_fall", 64'(busy), 64'd0);
      checkOutput("b2b_wr_count", 64'(wrCount - lastWr), 64'd16);

      // Randomized traffic with random idle gaps and fresh memory contents.
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      for (int i = 0; i < 16; i++) twRom[i] = $urandom;
      twRom[0] = 32'h7FFF_0000;
      twRom[1] = 32'h0000_8000;
      mem[0]   = 32'h8000_8000;
      mem[1]   = 32'h7FFF_7FFF;
      for (int i = 0; i < 80; i++) begin
         applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
